// File: rtl/reg_bank_pkg.sv
// Shared types and default sizing for the reg_bank register file and its reload sequencer.
package reg_bank_pkg;

  localparam int unsigned N_DEFAULT     = 16;
  localparam int unsigned DEPTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/reg_bank_clr_fsm.sv
// Reload sequencer: walks an index over every register, one per cycle, then pulses done.
module reg_bank_clr_fsm
  import reg_bank_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr_req,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_load,
  output logic [AW-1:0] o_load_idx
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  clr_state_e    r_state;
  clr_state_e    w_state_next;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // clr_req is only honoured from IDLE; it is ignored while clearing or in DONE.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      IDLE: begin
        if (i_clr_req) begin
          w_state_next = CLEAR;
          w_idx_next   = '0;
        end
      end
      CLEAR: begin
        if (r_idx == LAST_IDX) begin
          w_state_next = DONE;
          w_idx_next   = '0;
        end else begin
          w_idx_next = r_idx + AW'(1);
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (r_state == CLEAR);
    o_done     = (r_state == DONE);
    o_load     = (r_state == CLEAR);
    o_load_idx = r_idx;
  end

endmodule

// File: rtl/reg_bank.sv
// Dual-read, single-write register bank with a sequenced reload to RST_VAL.
// Define REG_BANK_BYPASS_EN for write-first read ports; default is read-first.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int unsigned         N       = N_DEFAULT,
  parameter int unsigned         DEPTH   = DEPTH_DEFAULT,
  parameter int unsigned         AW      = $clog2(DEPTH),
  parameter logic [DEPTH*N-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [N-1:0]  i_wdata,
  input  logic [AW-1:0] i_ra_addr,
  input  logic [AW-1:0] i_rb_addr,
  output logic [N-1:0]  o_ra_data,
  output logic [N-1:0]  o_rb_data,
  input  logic          i_clr_req,
  output logic          o_busy,
  output logic          o_done
);

  logic [N-1:0]  r_mem [DEPTH];
  logic [N-1:0]  r_ra_data;
  logic [N-1:0]  r_rb_data;
  logic          w_busy;
  logic          w_done;
  logic          w_load;
  logic [AW-1:0] w_load_idx;
  logic          w_wr_ok;
  logic [N-1:0]  w_ra;
  logic [N-1:0]  w_rb;
  logic [N-1:0]  w_ra_next;
  logic [N-1:0]  w_rb_next;

  reg_bank_clr_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_fsm (
    .clk        (clk),
    .rst        (rst),
    .i_clr_req  (i_clr_req),
    .o_busy     (w_busy),
    .o_done     (w_done),
    .o_load     (w_load),
    .o_load_idx (w_load_idx)
  );

  assign w_wr_ok = i_we && !w_busy && (32'(i_waddr) < DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= RST_VAL[i*N +: N];
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (w_load && (w_load_idx == AW'(i))) begin
          r_mem[i] <= RST_VAL[i*N +: N];
        end else if (w_wr_ok && (i_waddr == AW'(i))) begin
          r_mem[i] <= i_wdata;
        end
      end
    end
  end

  // Out-of-range addresses match no entry and therefore read as zero.
  always_comb begin
    w_ra = '0;
    w_rb = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i_ra_addr == AW'(i)) w_ra = r_mem[i];
      if (i_rb_addr == AW'(i)) w_rb = r_mem[i];
    end
  end

  always_comb begin
    w_ra_next = w_ra;
    w_rb_next = w_rb;
`ifdef REG_BANK_BYPASS_EN
    if (w_wr_ok && (i_waddr == i_ra_addr)) w_ra_next = i_wdata;
    if (w_wr_ok && (i_waddr == i_rb_addr)) w_rb_next = i_wdata;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ra_data <= '0;
      r_rb_data <= '0;
    end else begin
      r_ra_data <= w_ra_next;
      r_rb_data <= w_rb_next;
    end
  end

  assign o_ra_data = r_ra_data;
  assign o_rb_data = r_rb_data;
  assign o_busy    = w_busy;
  assign o_done    = w_done;

endmodule
